lcd_capture: RTL and testbench

Passive HD44780 bus decoder that sits directly downstream of the board's character-LCD driver, on the LCD_RS/LCD_E/LCD_D wires. It samples each write strobe, decodes the instruction or data byte, and keeps a 2×16 character shadow of the display. The host-side simulator reads this shadow through a registered read port so it can render the panel without modelling the controller.

---
 rtl/lcd_capture.sv | 184 ++++++++++++++++++
 tb/tb_lcd_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - passive HD44780 bus decoder keeping a 2x16 character shadow
module lcd_capture #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [7:0] lcd_d,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       two_line,
  output logic       busy,
  output logic       update,
  output logic       overrun
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic       e_q, rs_q;
  logic [7:0] d_q;
  logic [0:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       pend_v_q, pend_v_d, pend_rs_q, pend_rs_d;
  logic [7:0] pend_d_q, pend_d_d;
  logic [6:0] cursor_q, cursor_d;
  logic       inc_q, inc_d;
  logic       display_on_q, display_on_d;
  logic       two_line_q, two_line_d;
  logic       update_q, update_d;
  logic       overrun_q, overrun_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] mem_q [32];

  logic       strobe;
  logic       exec_v, exec_rs;
  logic [7:0] exec_d;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_data;

  // DDRAM counter stepping: the two 40-byte lines are joined end to end.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      next_addr = 7'h40;
      else if (a == 7'h67) next_addr = 7'h00;
      else                 next_addr = a + 7'd1;
    end else begin
      if (a == 7'h00)      next_addr = 7'h67;
      else if (a == 7'h40) next_addr = 7'h27;
      else                 next_addr = a - 7'd1;
    end
  endfunction

  always_comb begin
    strobe       = e_q & ~lcd_e;
    state_d      = state_q;
    idx_d        = idx_q;
    pend_v_d     = pend_v_q;
    pend_rs_d    = pend_rs_q;
    pend_d_d     = pend_d_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    display_on_d = display_on_q;
    two_line_d   = two_line_q;
    update_d     = 1'b0;
    overrun_d    = overrun_q;
    rd_data_d    = mem_q[rd_addr];
    exec_v       = 1'b0;
    exec_rs      = rs_q;
    exec_d       = d_q;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_data      = CLEAR_CHAR;

    if (state_q == S_SWEEP) begin
      wr_en = 1'b1;
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) begin
        state_d  = S_IDLE;
        update_d = 1'b1;
      end
      if (strobe) begin
        if (pend_v_q) begin
          overrun_d = 1'b1;
        end else begin
          pend_v_d  = 1'b1;
          pend_rs_d = rs_q;
          pend_d_d  = d_q;
        end
      end
    end else if (pend_v_q) begin
      // Pending entry runs first; a strobe landing now takes its place.
      exec_v    = 1'b1;
      exec_rs   = pend_rs_q;
      exec_d    = pend_d_q;
      pend_v_d  = strobe;
      pend_rs_d = rs_q;
      pend_d_d  = d_q;
    end else if (strobe) begin
      exec_v = 1'b1;
    end

    if (exec_v) begin
      if (exec_rs) begin
        if (cursor_q[5:4] == 2'b00) begin
          wr_en    = 1'b1;
          wr_idx   = {cursor_q[6], cursor_q[3:0]};
          wr_data  = exec_d;
          update_d = 1'b1;
        end
        cursor_d = next_addr(cursor_q, inc_q);
      end else begin
        casez (exec_d)
          8'b1???????: cursor_d = exec_d[6:0];
          8'b001?????: two_line_d = exec_d[3];
          8'b00001???: display_on_d = exec_d[2];
          8'b000001??: inc_d = exec_d[1];
          8'b0000001?: cursor_d = 7'h00;
          8'b00000001: begin
            cursor_d = 7'h00;
            inc_d    = 1'b1;
            state_d  = S_SWEEP;
            idx_d    = 5'd0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      d_q          <= 8'h00;
      state_q      <= S_SWEEP;
      idx_q        <= 5'd0;
      pend_v_q     <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_d_q     <= 8'h00;
      cursor_q     <= 7'h00;
      inc_q        <= 1'b1;
      display_on_q <= 1'b0;
      two_line_q   <= 1'b0;
      update_q     <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= CLEAR_CHAR;
    end else begin
      e_q          <= lcd_e;
      rs_q         <= lcd_rs;
      d_q          <= lcd_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_v_q     <= pend_v_d;
      pend_rs_q    <= pend_rs_d;
      pend_d_q     <= pend_d_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      display_on_q <= display_on_d;
      two_line_q   <= two_line_d;
      update_q     <= update_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Shadow contents are initialised by the reset sweep rather than a reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign display_on  = display_on_q;
  assign two_line    = two_line_q;
  assign busy        = (state_q == S_SWEEP);
  assign update      = update_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_capture.sv
// tb/tb_lcd_capture.sv - directed self-checking bench for lcd_capture
module tb_lcd_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_e = 1'b0;
  logic [7:0] lcd_d = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, two_line, busy, update, overrun;

  int checks = 0;
  int errors = 0;

  lcd_capture #(.CLEAR_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .two_line(two_line), .busy(busy),
    .update(update), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two-cycle strobe; on return the write has executed and update is visible.
  task automatic lcd_write(input logic rs, input logic [7:0] d);
    lcd_rs = rs;
    lcd_d  = d;
    lcd_e  = 1'b1;
    step(1);
    lcd_e  = 1'b0;
    step(1);
  endtask

  task automatic read_shadow(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    step(1);
    v = rd_data;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (busy && n < 200) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] v;
    int bad;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b1 || cursor_addr !== 7'h00 || display_on !== 1'b0 || overrun !== 1'b0 || update !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b cursor=%h disp=%b ovr=%b upd=%b required 1 00 0 0 0", busy, cursor_addr, display_on, overrun, update);
    end
    busy_cycles(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d required 32", n);
    end
    checks++;
    if (update !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep_update: got %b required 1", update);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      read_shadow(5'(i), v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_fill: %0d locations not 0x20 required 0", bad);
    end
  endtask

  task automatic test_init;
    logic [7:0] seq [8];
    int n;
    seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    for (int i = 0; i < 8; i++) begin
      lcd_write(1'b0, seq[i]);
      if (seq[i] == 8'h01) begin
        busy_cycles(n);
        checks++;
        if (n !== 32) begin
          errors++;
          $display("FAIL init_clear_busy: got %0d required 32", n);
        end
        step(40 - n);
      end else begin
        if (seq[i] == 8'h08) begin
          checks++;
          if (display_on !== 1'b0) begin
            errors++;
            $display("FAIL init_display_off: got %b required 0", display_on);
          end
        end
        step(40);
      end
    end
    checks++;
    if (two_line !== 1'b1 || display_on !== 1'b1 || cursor_addr !== 7'h00) begin
      errors++;
      $display("FAIL init_final: two_line=%b disp=%b cursor=%h required 1 1 00", two_line, display_on, cursor_addr);
    end
  endtask

  task automatic test_data;
    logic [7:0] v;
    int pulses = 0;
    lcd_write(1'b0, 8'h80);
    lcd_write(1'b1, 8'h41);
    if (update === 1'b1) pulses++;
    step(1);
    lcd_write(1'b1, 8'h42);
    if (update === 1'b1) pulses++;
    step(1);
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL data_update_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (cursor_addr !== 7'h02) begin
      errors++;
      $display("FAIL data_cursor: got %h required 02", cursor_addr);
    end
    read_shadow(5'd0, v);
    checks++;
    if (v !== 8'h41) begin
      errors++;
      $display("FAIL data_addr0: got %h required 41", v);
    end
    read_shadow(5'd1, v);
    checks++;
    if (v !== 8'h42) begin
      errors++;
      $display("FAIL data_addr1: got %h required 42", v);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    lcd_write(1'b0, 8'hA7);
    lcd_write(1'b1, 8'h58);
    checks++;
    if (update !== 1'b0 || cursor_addr !== 7'h40) begin
      errors++;
      $display("FAIL wrap_offscreen: upd=%b cursor=%h required 0 40", update, cursor_addr);
    end
    lcd_write(1'b0, 8'h04);
    lcd_write(1'b1, 8'h59);
    checks++;
    if (update !== 1'b1 || cursor_addr !== 7'h27) begin
      errors++;
      $display("FAIL wrap_dec: upd=%b cursor=%h required 1 27", update, cursor_addr);
    end
    read_shadow(5'd16, v);
    checks++;
    if (v !== 8'h59) begin
      errors++;
      $display("FAIL wrap_line1: got %h required 59", v);
    end
    lcd_write(1'b0, 8'h80);
    lcd_write(1'b1, 8'h33);
    checks++;
    if (cursor_addr !== 7'h67) begin
      errors++;
      $display("FAIL wrap_dec_zero: got %h required 67", cursor_addr);
    end
    lcd_write(1'b0, 8'h06);
    lcd_write(1'b1, 8'h34);
    checks++;
    if (cursor_addr !== 7'h00 || update !== 1'b0) begin
      errors++;
      $display("FAIL wrap_inc_67: cursor=%h upd=%b required 00 0", cursor_addr, update);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    int n;
    lcd_write(1'b0, 8'h01);
    step(2);
    lcd_write(1'b1, 8'h5A);
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL pend_first: busy=%b ovr=%b required 1 0", busy, overrun);
    end
    step(2);
    lcd_write(1'b1, 8'h5B);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL pend_overrun: got %b required 1", overrun);
    end
    busy_cycles(n);
    step(2);
    checks++;
    if (n > 32 || cursor_addr !== 7'h01) begin
      errors++;
      $display("FAIL pend_exec: busy_left=%0d cursor=%h required <=32 01", n, cursor_addr);
    end
    read_shadow(5'd0, v);
    checks++;
    if (v !== 8'h5A) begin
      errors++;
      $display("FAIL pend_addr0: got %h required 5A", v);
    end
    read_shadow(5'd1, v);
    checks++;
    if (v !== 8'h20) begin
      errors++;
      $display("FAIL pend_dropped: got %h required 20", v);
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic [7:0] v;
    int n;
    lcd_write(1'b0, 8'h01);
    lcd_write(1'b1, 8'h77);
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: ovr=%b busy=%b required 0 1", overrun, busy);
    end
    busy_cycles(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL midreset_busy_len: got %0d required 32", n);
    end
    step(3);
    read_shadow(5'd0, v);
    checks++;
    if (v !== 8'h20 || cursor_addr !== 7'h00) begin
      errors++;
      $display("FAIL midreset_pending_discard: data=%h cursor=%h required 20 00", v, cursor_addr);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_data;
    test_wrap;
    test_back_to_back;
    test_reset_mid_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
